// File: rtl/pc_pkg.sv
// Shared constants, next-PC select encoding and alignment helper for the fetch PC unit.
package pc_pkg;

  localparam int unsigned PC_INCR = 4;

  typedef enum logic [2:0] {
    NPC_REDIRECT,
    NPC_HOLD,
    NPC_RAS,
    NPC_CALL,
    NPC_SEQ
  } npc_sel_e;

  // Widest supported PC is 64 bits; callers truncate back to their own width.
  function automatic logic [63:0] align4(input logic [63:0] a);
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// and a simultaneous push+pop replaces the top entry in place.
module return_addr_stack #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [DATA_WIDTH-1:0]          push_data,
  output logic [DATA_WIDTH-1:0]          top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           empty
);

  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         w_top_ptr;
  logic [PW-1:0]         w_wptr_inc;

  // Explicit wrap so non-power-of-two depths stay modulo RAS_DEPTH.
  always_comb begin
    w_top_ptr  = (r_wptr == '0) ? PW'(RAS_DEPTH - 1) : r_wptr - 1'b1;
    w_wptr_inc = (r_wptr == PW'(RAS_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
    end else if (push && pop && (r_count != '0)) begin
      r_mem[w_top_ptr] <= push_data;
    end else if (push) begin
      r_mem[r_wptr] <= push_data;
      r_wptr        <= w_wptr_inc;
      if (r_count != CW'(RAS_DEPTH)) r_count <= r_count + 1'b1;
    end else if (pop && (r_count != '0)) begin
      r_wptr  <= w_top_ptr;
      r_count <= r_count - 1'b1;
    end
  end

  assign top   = r_mem[w_top_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC register with redirect/stall priority and call/return
// prediction through an internal return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned    RAS_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           Stall_i,
  input  logic                           RedirectEn_i,
  input  logic [DATA_WIDTH-1:0]          RedirectPC_i,
  input  logic                           CallF_i,
  input  logic                           RetF_i,
  input  logic [DATA_WIDTH-1:0]          JalTargetF_i,
  output logic [DATA_WIDTH-1:0]          PC_o,
  output logic [DATA_WIDTH-1:0]          PCPlus4_o,
  output logic [DATA_WIDTH-1:0]          PredPCNext_o,
  output logic                           PredTaken_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount_o
);

  function automatic logic [DATA_WIDTH-1:0] al(input logic [DATA_WIDTH-1:0] a);
    return DATA_WIDTH'(align4(64'(a)));
  endfunction

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_ras_top;
  logic [DATA_WIDTH-1:0] w_pred;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic                  w_ras_empty;
  logic                  w_ret_hit;
  logic                  w_push;
  logic                  w_pop;
  npc_sel_e              w_sel;

  assign w_pc_plus4 = r_pc + DATA_WIDTH'(PC_INCR);
  assign w_ret_hit  = RetF_i && !w_ras_empty;

  // Prediction ignores stall/redirect so it can travel with the instruction.
  always_comb begin
    w_pred = w_pc_plus4;
    if (w_ret_hit)    w_pred = al(w_ras_top);
    else if (CallF_i) w_pred = al(JalTargetF_i);
  end

  always_comb begin
    w_sel = NPC_SEQ;
    if (RedirectEn_i)   w_sel = NPC_REDIRECT;
    else if (Stall_i)   w_sel = NPC_HOLD;
    else if (w_ret_hit) w_sel = NPC_RAS;
    else if (CallF_i)   w_sel = NPC_CALL;
  end

  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_sel)
      NPC_REDIRECT: w_pc_next = al(RedirectPC_i);
      NPC_HOLD:     w_pc_next = r_pc;
      NPC_RAS:      w_pc_next = w_pred;
      NPC_CALL:     w_pc_next = w_pred;
      default:      w_pc_next = w_pc_plus4;
    endcase
  end

  assign w_push = (w_sel == NPC_RAS || w_sel == NPC_CALL) && CallF_i;
  assign w_pop  = (w_sel == NPC_RAS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= al(RESET_VECTOR);
    else     r_pc <= w_pc_next;
  end

  return_addr_stack #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus4),
    .top       (w_ras_top),
    .count     (RasCount_o),
    .empty     (w_ras_empty)
  );

  assign PC_o         = r_pc;
  assign PCPlus4_o    = w_pc_plus4;
  assign PredPCNext_o = w_pred;
  assign PredTaken_o  = w_ret_hit || CallF_i;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: scenario tasks with a queue of expected PCs.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_i, RedirectEn_i, CallF_i, RetF_i;
  logic [31:0] RedirectPC_i, JalTargetF_i;
  logic [31:0] PC_o, PCPlus4_o, PredPCNext_o;
  logic        PredTaken_o;
  logic [2:0]  RasCount_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] expq[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  pc_unit #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000),
    .RAS_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Stall_i      (Stall_i),
    .RedirectEn_i (RedirectEn_i),
    .RedirectPC_i (RedirectPC_i),
    .CallF_i      (CallF_i),
    .RetF_i       (RetF_i),
    .JalTargetF_i (JalTargetF_i),
    .PC_o         (PC_o),
    .PCPlus4_o    (PCPlus4_o),
    .PredPCNext_o (PredPCNext_o),
    .PredTaken_o  (PredTaken_o),
    .RasCount_o   (RasCount_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Stall_i = 0; RedirectEn_i = 0; CallF_i = 0; RetF_i = 0;
    RedirectPC_i = '0; JalTargetF_i = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
  endtask

  task automatic go_to(input logic [31:0] pc);
    RedirectEn_i = 1; RedirectPC_i = pc;
    tick();
    RedirectEn_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (PC_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", PC_o); end
    n_cmp++; if (RasCount_o !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", RasCount_o); end
    rst = 0;
    for (int i = 0; i < 4; i++) expq.push_back(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      exp_v = expq.pop_front();
      n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL seq_pc: got %h want %h", PC_o, exp_v); end
      n_cmp++; if (PCPlus4_o !== exp_v + 4) begin n_err++; $display("FAIL seq_plus4: got %h want %h", PCPlus4_o, exp_v + 4); end
      n_cmp++; if (PredTaken_o !== 1'b0) begin n_err++; $display("FAIL seq_taken: got %b want 0", PredTaken_o); end
      if (i < 3) tick();
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    go_to(32'h100);
    CallF_i = 1; JalTargetF_i = 32'h400;
    #1;
    n_cmp++; if (PredPCNext_o !== 32'h400) begin n_err++; $display("FAIL call_pred: got %h want 400", PredPCNext_o); end
    n_cmp++; if (PredTaken_o !== 1'b1) begin n_err++; $display("FAIL call_taken: got %b want 1", PredTaken_o); end
    expq.push_back(32'h400);
    tick();
    CallF_i = 0;
    exp_v = expq.pop_front();
    n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL call_pc: got %h want %h", PC_o, exp_v); end
    n_cmp++; if (RasCount_o !== 3'd1) begin n_err++; $display("FAIL call_cnt: got %0d want 1", RasCount_o); end
    repeat (3) tick();
    n_cmp++; if (PC_o !== 32'h40C) begin n_err++; $display("FAIL call_body: got %h want 40c", PC_o); end
    RetF_i = 1;
    #1;
    n_cmp++; if (PredPCNext_o !== 32'h104) begin n_err++; $display("FAIL ret_pred: got %h want 104", PredPCNext_o); end
    expq.push_back(32'h104);
    tick();
    RetF_i = 0;
    exp_v = expq.pop_front();
    n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL ret_pc: got %h want %h", PC_o, exp_v); end
    n_cmp++; if (RasCount_o !== 3'd0) begin n_err++; $display("FAIL ret_cnt: got %0d want 0", RasCount_o); end
  endtask

  task automatic test_nested();
    logic [2:0] exp_cnt;
    do_reset();
    go_to(32'h10);
    for (int i = 0; i < 5; i++) begin
      CallF_i = 1; JalTargetF_i = 32'h20 + 32'(16 * i);
      expq.push_back(JalTargetF_i);
      tick();
      exp_v   = expq.pop_front();
      exp_cnt = (i < 3) ? 3'(i + 1) : 3'd4;
      n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL nest_call_pc[%0d]: got %h want %h", i, PC_o, exp_v); end
      n_cmp++; if (RasCount_o !== exp_cnt) begin n_err++; $display("FAIL nest_cnt[%0d]: got %0d want %0d", i, RasCount_o, exp_cnt); end
    end
    CallF_i = 0;
    expq.push_back(32'h54); expq.push_back(32'h44); expq.push_back(32'h34);
    expq.push_back(32'h24); expq.push_back(32'h28);
    for (int i = 0; i < 5; i++) begin
      RetF_i = 1;
      #1;
      exp_v = expq.pop_front();
      n_cmp++; if (PredPCNext_o !== exp_v) begin n_err++; $display("FAIL nest_ret_pred[%0d]: got %h want %h", i, PredPCNext_o, exp_v); end
      n_cmp++; if (PredTaken_o !== (i < 4)) begin n_err++; $display("FAIL nest_ret_taken[%0d]: got %b want %b", i, PredTaken_o, (i < 4)); end
      tick();
      exp_cnt = (i < 4) ? 3'(3 - i) : 3'd0;
      n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL nest_ret_pc[%0d]: got %h want %h", i, PC_o, exp_v); end
      n_cmp++; if (RasCount_o !== exp_cnt) begin n_err++; $display("FAIL nest_ret_cnt[%0d]: got %0d want %0d", i, RasCount_o, exp_cnt); end
    end
    RetF_i = 0;
  endtask

  task automatic test_redirect_stall();
    do_reset();
    CallF_i = 1; JalTargetF_i = 32'h100;
    tick();
    Stall_i = 1; RedirectEn_i = 1; RedirectPC_i = 32'h203; CallF_i = 1; JalTargetF_i = 32'h503;
    expq.push_back(32'h200);
    tick();
    RedirectEn_i = 0;
    exp_v = expq.pop_front();
    n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL redir_pc: got %h want %h", PC_o, exp_v); end
    n_cmp++; if (RasCount_o !== 3'd1) begin n_err++; $display("FAIL redir_cnt: got %0d want 1", RasCount_o); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (PredPCNext_o !== 32'h500) begin n_err++; $display("FAIL stall_pred[%0d]: got %h want 500", i, PredPCNext_o); end
      tick();
      n_cmp++; if (PC_o !== 32'h200) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want 200", i, PC_o); end
      n_cmp++; if (RasCount_o !== 3'd1) begin n_err++; $display("FAIL stall_cnt[%0d]: got %0d want 1", i, RasCount_o); end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    go_to(32'h10);
    CallF_i = 1; JalTargetF_i = 32'h20;
    tick();
    CallF_i = 0;
    go_to(32'h7C);
    CallF_i = 1; JalTargetF_i = 32'h90;
    tick();
    CallF_i = 0;
    go_to(32'h300);
    n_cmp++; if (RasCount_o !== 3'd2) begin n_err++; $display("FAIL b2b_pre_cnt: got %0d want 2", RasCount_o); end
    CallF_i = 1; RetF_i = 1; JalTargetF_i = 32'h998;
    #1;
    n_cmp++; if (PredPCNext_o !== 32'h80) begin n_err++; $display("FAIL b2b_pred: got %h want 80", PredPCNext_o); end
    expq.push_back(32'h80);
    tick();
    CallF_i = 0;
    exp_v = expq.pop_front();
    n_cmp++; if (PC_o !== exp_v) begin n_err++; $display("FAIL b2b_pc: got %h want %h", PC_o, exp_v); end
    n_cmp++; if (RasCount_o !== 3'd2) begin n_err++; $display("FAIL b2b_cnt: got %0d want 2", RasCount_o); end
    #1;
    n_cmp++; if (PredPCNext_o !== 32'h304) begin n_err++; $display("FAIL b2b_top: got %h want 304", PredPCNext_o); end
    tick();
    n_cmp++; if (PC_o !== 32'h304) begin n_err++; $display("FAIL b2b_ret_pc: got %h want 304", PC_o); end
    n_cmp++; if (RasCount_o !== 3'd1) begin n_err++; $display("FAIL b2b_ret_cnt: got %0d want 1", RasCount_o); end
    #1;
    n_cmp++; if (PredPCNext_o !== 32'h14) begin n_err++; $display("FAIL b2b_old: got %h want 14", PredPCNext_o); end
    idle();
  endtask

  task automatic test_wrap_reset();
    do_reset();
    CallF_i = 1; JalTargetF_i = 32'h40;
    tick();
    CallF_i = 0;
    go_to(32'hFFFF_FFFC);
    n_cmp++; if (PCPlus4_o !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want 0", PCPlus4_o); end
    tick();
    n_cmp++; if (PC_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", PC_o); end
    tick();
    n_cmp++; if (RasCount_o !== 3'd1) begin n_err++; $display("FAIL wrap_cnt: got %0d want 1", RasCount_o); end
    #2;
    rst = 1;
    #1;
    n_cmp++; if (PC_o !== 32'h0) begin n_err++; $display("FAIL async_rst_pc: got %h want 0", PC_o); end
    n_cmp++; if (RasCount_o !== 3'd0) begin n_err++; $display("FAIL async_rst_cnt: got %0d want 0", RasCount_o); end
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_call_ret();
    test_nested();
    test_redirect_stall();
    test_back_to_back();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
